// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, WIDTH clocks per add.
// Start accepted in IDLE or DONE; result registered and held until the next completion or reset.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_carry_in,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_busy,
  output logic             o_done
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
  logic             c_q, cout_q, busy_q, done_q;
  logic [CW-1:0]    cnt_q;

  logic             s_d, c_d;
  logic [WIDTH-1:0] psum_d;

  assign s_d    = a_q[0] ^ b_q[0] ^ c_q;
  assign c_d    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign psum_d = {s_d, psum_q[WIDTH-1:1]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a start exactly like IDLE so back-to-back ops lose no cycle
        S_IDLE, S_DONE: begin
          if (i_start) begin
            a_q     <= i_op1;
            b_q     <= i_op2;
            c_q     <= i_carry_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ADD: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          c_q    <= c_d;
          psum_q <= psum_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q   <= psum_d;
            cout_q  <= c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_sum       = sum_q;
  assign o_carry_out = cout_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule
